// File: rtl/mips_iter_alu.sv
// Multi-cycle MIPS ALU: single-cycle logic/arith ops plus iterative unsigned
// multiply (shift-add) and divide (restoring), with valid/ready on both sides.
module mips_iter_alu #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int CNT_W   = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             carry,
   output logic             div_by_zero
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOR  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_SLTU = 4'd7;
   localparam logic [3:0] OP_SLL  = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;
   localparam logic [3:0] OP_SRA  = 4'd10;
   localparam logic [3:0] OP_MULU = 4'd11;
   localparam logic [3:0] OP_DIVU = 4'd12;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
   logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
   logic             zero_q, zero_d, carry_q, carry_d, dbz_q, dbz_d;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_carry;
   logic [WIDTH:0]     add_w;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [WIDTH-1:0]   iter_hi, iter_lo;
   logic               accept;

   always_comb begin
      shamt     = b[SHAMT_W-1:0];
      add_w     = {1'b0, a} + {1'b0, b};
      alu_res   = add_w[WIDTH-1:0];
      alu_carry = add_w[WIDTH];
      case (op)
         OP_SUB:  begin alu_res = a - b; alu_carry = (a < b); end
         OP_AND:  begin alu_res = a & b; alu_carry = 1'b0; end
         OP_OR:   begin alu_res = a | b; alu_carry = 1'b0; end
         OP_XOR:  begin alu_res = a ^ b; alu_carry = 1'b0; end
         OP_NOR:  begin alu_res = ~(a | b); alu_carry = 1'b0; end
         OP_SLT:  begin alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))}; alu_carry = 1'b0; end
         OP_SLTU: begin alu_res = {{(WIDTH-1){1'b0}}, (a < b)}; alu_carry = 1'b0; end
         OP_SLL:  begin alu_res = a << shamt; alu_carry = 1'b0; end
         OP_SRL:  begin alu_res = a >> shamt; alu_carry = 1'b0; end
         OP_SRA:  begin alu_res = $unsigned($signed(a) >>> shamt); alu_carry = 1'b0; end
         default: ;
      endcase
   end

   // One iteration step: hi/lo form the product pair (MUL) or remainder/quotient pair (DIV)
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb_q};
      iter_hi   = mul_sum[WIDTH:1];
      iter_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
      if (state_q == S_DIV) begin
         if (!div_diff[WIDTH]) begin
            iter_hi = div_diff[WIDTH-1:0];
            iter_lo = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            iter_hi = div_shift[WIDTH-1:0];
            iter_lo = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == S_DONE);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opb_d    = opb_q;
      res_d    = res_q;
      res_hi_d = res_hi_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      dbz_d    = dbz_q;

      case (state_q)
         S_MUL, S_DIV: begin
            hi_d  = iter_hi;
            lo_d  = iter_lo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               state_d  = S_DONE;
               cnt_d    = '0;
               res_d    = iter_lo;
               res_hi_d = iter_hi;
               zero_d   = (iter_lo == '0);
               carry_d  = 1'b0;
               dbz_d    = 1'b0;
            end
         end
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: ;
      endcase

      // Accept only happens in IDLE/DONE, so it overrides the hand-back above
      if (accept) begin
         cnt_d = '0;
         if (op == OP_MULU) begin
            state_d = S_MUL;
            hi_d    = '0;
            lo_d    = b;
            opb_d   = a;
         end else if (op == OP_DIVU && b != '0) begin
            state_d = S_DIV;
            hi_d    = '0;
            lo_d    = a;
            opb_d   = b;
         end else if (op == OP_DIVU) begin
            state_d  = S_DONE;
            res_d    = '1;
            res_hi_d = a;
            zero_d   = 1'b0;
            carry_d  = 1'b0;
            dbz_d    = 1'b1;
         end else begin
            state_d  = S_DONE;
            res_d    = alu_res;
            res_hi_d = '0;
            zero_d   = (alu_res == '0);
            carry_d  = alu_carry;
            dbz_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opb_q    <= '0;
         res_q    <= '0;
         res_hi_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opb_q    <= opb_d;
         res_q    <= res_d;
         res_hi_q <= res_hi_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         dbz_q    <= dbz_d;
      end
   end

   assign result      = res_q;
   assign result_hi   = res_hi_q;
   assign zero        = zero_q;
   assign carry       = carry_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_iter_alu.sv
// Self-checking bench for mips_iter_alu: directed vector table, randomized ops
// against an arithmetic reference model, plus backpressure and reset sequences.
module tb_mips_iter_alu;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op = 4'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result, result_hi;
   logic        zero, carry, div_by_zero;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mips_iter_alu #(.WIDTH(32), .SHAMT_W(5), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_hi(result_hi), .zero(zero), .carry(carry),
      .div_by_zero(div_by_zero)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b, r, hi;
      logic        z, c, d;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model from plain arithmetic on the operands
   function automatic void model(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                                 output logic [31:0] r, output logic [31:0] hi,
                                 output logic z, output logic c, output logic d, output int lat);
      logic [32:0] s;
      logic [63:0] p;
      r = 0; hi = 0; c = 0; d = 0; lat = 1;
      case (o)
         4'd1:  begin r = va - vb; c = (va < vb); end
         4'd2:  r = va & vb;
         4'd3:  r = va | vb;
         4'd4:  r = va ^ vb;
         4'd5:  r = ~(va | vb);
         4'd6:  r = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
         4'd7:  r = (va < vb) ? 32'd1 : 32'd0;
         4'd8:  r = va << vb[4:0];
         4'd9:  r = va >> vb[4:0];
         4'd10: r = $unsigned($signed(va) >>> vb[4:0]);
         4'd11: begin p = {32'd0, va} * {32'd0, vb}; r = p[31:0]; hi = p[63:32]; lat = 33; end
         4'd12: begin
            if (vb == 0) begin r = 32'hFFFF_FFFF; hi = va; d = 1; end
            else begin r = va / vb; hi = va % vb; lat = 33; end
         end
         default: begin s = {1'b0, va} + {1'b0, vb}; r = s[31:0]; c = s[32]; end
      endcase
      z = (r == 0);
   endfunction

   task automatic do_op(input string tag, input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] er, input logic [31:0] ehi,
                        input logic ez, input logic ec, input logic ed, input int elat);
      int  lat;
      int  guard;
      bit  busy_ok;
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check({tag, " in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1; op = o; a = va; b = vb; out_ready = 1;
      @(posedge clk);
      #1;
      in_valid = 0; op = 4'($urandom); a = $urandom; b = $urandom;
      @(negedge clk);
      lat = 1;
      busy_ok = 1;
      while (!out_valid && lat < 100) begin
         if (in_ready) busy_ok = 0;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({tag, " latency"}, 64'(lat), 64'(elat));
      check({tag, " result"}, 64'(result), 64'(er));
      check({tag, " result_hi"}, 64'(result_hi), 64'(ehi));
      check({tag, " flags"}, 64'({zero, carry, div_by_zero}), 64'({ez, ec, ed}));
      if (elat > 1) check({tag, " busy in_ready"}, 64'(busy_ok), 64'd1);
      $display("op=%0d a=0x%08h b=0x%08h -> result=0x%08h hi=0x%08h z=%0b c=%0b dbz=%0b lat=%0d",
               o, va, vb, result, result_hi, zero, carry, div_by_zero, lat);
      @(posedge clk);
      @(negedge clk);
      check({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
   endtask

   vec_t tbl[16];

   initial begin
      logic [3:0]  ro;
      logic [31:0] ra, rb, er, ehi;
      logic        ez, ec, ed;
      int          elat;
      bit          quiet;

      tbl[0]  = '{4'd0,  32'hFFFF_FFFF, 32'd1,        32'd0,          32'd0,          1'b1, 1'b1, 1'b0, 1};
      tbl[1]  = '{4'd1,  32'd3,         32'd5,        32'hFFFF_FFFE,  32'd0,          1'b0, 1'b1, 1'b0, 1};
      tbl[2]  = '{4'd11, 32'h0001_0000, 32'h0001_0000, 32'd0,         32'd1,          1'b1, 1'b0, 1'b0, 33};
      tbl[3]  = '{4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0, 33};
      tbl[4]  = '{4'd12, 32'd100,       32'd7,        32'd14,         32'd2,          1'b0, 1'b0, 1'b0, 33};
      tbl[5]  = '{4'd12, 32'd5,         32'd0,        32'hFFFF_FFFF,  32'd5,          1'b0, 1'b0, 1'b1, 1};
      tbl[6]  = '{4'd6,  32'hFFFF_FFFF, 32'd1,        32'd1,          32'd0,          1'b0, 1'b0, 1'b0, 1};
      tbl[7]  = '{4'd7,  32'hFFFF_FFFF, 32'd1,        32'd0,          32'd0,          1'b1, 1'b0, 1'b0, 1};
      tbl[8]  = '{4'd10, 32'h8000_0000, 32'd4,        32'hF800_0000,  32'd0,          1'b0, 1'b0, 1'b0, 1};
      tbl[9]  = '{4'd9,  32'h8000_0000, 32'd4,        32'h0800_0000,  32'd0,          1'b0, 1'b0, 1'b0, 1};
      tbl[10] = '{4'd8,  32'd1,         32'h25,       32'h20,         32'd0,          1'b0, 1'b0, 1'b0, 1};
      tbl[11] = '{4'd5,  32'd0,         32'd0,        32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 1'b0, 1};
      tbl[12] = '{4'd4,  32'hFF,        32'h0F,       32'hF0,         32'd0,          1'b0, 1'b0, 1'b0, 1};
      tbl[13] = '{4'd13, 32'd5,         32'd6,        32'd11,         32'd0,          1'b0, 1'b0, 1'b0, 1};
      tbl[14] = '{4'd12, 32'd7,         32'd100,      32'd0,          32'd7,          1'b1, 1'b0, 1'b0, 33};
      tbl[15] = '{4'd0,  32'd1,         32'd1,        32'd2,          32'd0,          1'b0, 1'b0, 1'b0, 1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset outputs", {result, result_hi}, 64'd0);
      check("reset flags", 64'({zero, carry, div_by_zero}), 64'd0);
      reset = 1;

      for (int i = 0; i < 16; i++)
         do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].hi,
               tbl[i].z, tbl[i].c, tbl[i].d, tbl[i].lat);

      for (int i = 0; i < 40; i++) begin
         ro = 4'($urandom_range(0, 15));
         ra = $urandom;
         rb = $urandom;
         if (ro == 4'd12) begin
            if ($urandom_range(0, 3) == 0) rb = 0;
            else if ($urandom_range(0, 1) == 0) rb = $urandom_range(1, 300);
         end
         model(ro, ra, rb, er, ehi, ez, ec, ed, elat);
         do_op($sformatf("rand%0d", i), ro, ra, rb, er, ehi, ez, ec, ed, elat);
      end

      // Backpressure: ADD held for 5 cycles, then AND issued in the hand-off cycle
      @(negedge clk);
      out_ready = 0; in_valid = 1; op = 4'd0; a = 32'd1; b = 32'd2;
      @(posedge clk);
      #1 in_valid = 0;
      @(negedge clk);
      check("bp first valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("bp hold%0d", i),
               {result[31:0], 8'(out_valid), 8'(in_ready), 8'({zero, carry, div_by_zero}), 8'd0},
               {32'd3, 8'd1, 8'd0, 8'd0, 8'd0});
      end
      out_ready = 1; in_valid = 1; op = 4'd2; a = 32'hF0F0; b = 32'hFF00;
      #1 check("bp in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 0;
      @(negedge clk);
      check("b2b out_valid", 64'(out_valid), 64'd1);
      check("b2b result", 64'(result), 64'h0000_F000);
      $display("backpressure: AND result=0x%08h out_valid=%0b", result, out_valid);
      @(posedge clk);
      @(negedge clk);
      check("b2b drop", 64'(out_valid), 64'd0);

      // Reset in the middle of a multiply
      in_valid = 1; op = 4'd11; a = 32'h1234_5678; b = 32'h9ABC_DEF0; out_ready = 1;
      @(posedge clk);
      #1 in_valid = 0;
      repeat (10) @(posedge clk);
      #2 reset = 0;
      #1;
      check("rst out_valid", 64'(out_valid), 64'd0);
      check("rst outputs", {result, result_hi}, 64'd0);
      check("rst flags", 64'({zero, carry, div_by_zero}), 64'd0);
      @(negedge clk);
      reset = 1;
      #1 check("rst in_ready", 64'(in_ready), 64'd1);
      quiet = 1;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) quiet = 0;
      end
      check("rst no stale result", 64'(quiet), 64'd1);
      $display("reset mid-MULU: out_valid stayed %0b for 40 cycles", !quiet);
      do_op("post-reset add", 4'd0, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mips_iter_alu.md
Name: mips_iter_alu

Overview:
- Parametrised multi-cycle ALU for the next-generation MIPS datapath.
- Adds iterative unsigned multiply and divide to the existing single-cycle operations, producing hi/lo results.
- Uses a valid/ready handshake on both input and output, so the core can stall on long operations.
- Sits between the control unit/register file and the writeback stage.

Parameters:
- WIDTH, 32, operand/result width; must equal 2**SHAMT_W, minimum 8.
- SHAMT_W, 5, shift-amount width; taken from b[SHAMT_W-1:0].
- CNT_W, 6, iteration counter width; must be at least SHAMT_W+1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- op  in  4  operation code
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt/imm); shift amount in low SHAMT_W bits
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  WIDTH  primary result (lo / quotient)
- result_hi  out  WIDTH  product high half / remainder; 0 for all other ops
- zero  out  1  result == 0
- carry  out  1  ADD carry-out; SUB borrow (a<b unsigned); 0 otherwise
- div_by_zero  out  1  DIVU with b == 0

Behaviour:
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA
  - 11 MULU, 12 DIVU
  - 13-15 reserved: behave as ADD.
- Reset (reset low, async): state IDLE; out_valid=0, result=0, result_hi=0, zero=0, carry=0, div_by_zero=0, counter=0. An in-flight operation is aborted and no result is ever presented for it.
- Accept condition: in_valid && in_ready at a rising edge. a, b and op are captured into internal registers at accept; input changes afterwards are ignored.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue when the consumer is taking the result.
- States:
  - IDLE: on accept, go to DONE for single-cycle ops and DIVU with b==0, to MUL for MULU, to DIV for DIVU with b!=0.
  - MUL: shift-add, one multiplier bit per cycle, WIDTH cycles. Counter runs 0..WIDTH-1, then DONE. Full 2*WIDTH-bit unsigned product: result = low half, result_hi = high half.
  - DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then DONE. result = quotient, result_hi = remainder.
  - DONE: out_valid=1; outputs held stable while out_ready=0. When out_ready=1: go to IDLE, or start the next op directly if in_valid is also 1 in that cycle.
- Latency (accept edge to out_valid high):
  - single-cycle ops: 1 cycle
  - MULU: WIDTH+1
  - DIVU: WIDTH+1
  - DIVU with b==0: 1 cycle
- Divide by zero: result = all ones, result_hi = a, div_by_zero=1.
- Arithmetic: ADD/SUB are modulo 2**WIDTH. SLT/SLTU produce 1 or 0 in result[0], upper bits 0.
- Shifts: shift a by b[SHAMT_W-1:0]. SRA replicates a[WIDTH-1].
- Flags: zero, carry and div_by_zero are registered together with result and are valid only while out_valid=1. carry=0 for all ops other than ADD and SUB.
- Back-to-back issue: a new accept in DONE replaces the outputs with the new op's values at its completion. For a single-cycle op this means out_valid stays 1 and the new values appear on the next edge.
- out_valid never deasserts without an out_ready handshake, except on reset.

Test Plan:
- ADD a=0xFFFFFFFF, b=1 -> result=0, zero=1, carry=1, out_valid exactly 1 cycle after accept. SUB a=3, b=5 -> result=0xFFFFFFFE, carry=1.
- MULU a=0x00010000, b=0x00010000 -> result=0, result_hi=1, out_valid at accept+33; in_ready=0 throughout MUL. MULU 0xFFFFFFFF*0xFFFFFFFF -> result=1, result_hi=0xFFFFFFFE.
- DIVU a=100, b=7 -> result=14, result_hi=2, latency 33. DIVU a=5, b=0 -> result=0xFFFFFFFF, result_hi=5, div_by_zero=1, latency 1.
- Signed/shift ops:
  - SLT a=0xFFFFFFFF, b=1 -> result 1
  - SLTU same operands -> result 0
  - SRA a=0x80000000, b=4 -> 0xF8000000
  - SRL same -> 0x08000000
  - SLL a=1, b=0x25 (shift 5) -> 0x20
- Backpressure: hold out_ready=0 for 5 cycles after ADD completes -> result and flags stable, in_ready=0. Then raise out_ready with in_valid=1 (AND 0xF0F0, 0xFF00) -> accepted that cycle, next cycle result=0xF000, out_valid still 1.
- Reset mid-MULU (reset low at cycle 10 of 32) -> out_valid=0 and all outputs 0 immediately. After release in_ready=1, no stale result; a fresh ADD 2+3 returns 5.
